// File: rtl/au_seq.sv
// Multi-cycle sequencer in front of the 8-bit arithmetic unit: one requester,
// start/busy/done handshake, registered AU controls and a MUL built from repeated adds.
module au_seq #(
    parameter int         WIDTH  = 8,
    parameter logic [3:0] AC_ADD = 4'b1000,
    parameter logic [3:0] AC_SUB = 4'b1001,
    parameter logic [3:0] AC_MOV = 4'b0100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             au_en,
    output logic [3:0]       ac,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    input  logic [WIDTH-1:0] au_t,
    input  logic             au_gf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_ITER = 2'b10,
        S_DONE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MOV = 2'b10,
        OP_MUL = 2'b11
    } op_t;

    state_t           state;
    op_t              op_q;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic             ovf;
    logic             ovf_next;
    logic [3:0]       exec_code;
    op_t              op_in;

    assign op_in = op_t'(op);

    always_comb begin
        exec_code = AC_ADD;
        case (op_in)
            OP_SUB:  exec_code = AC_SUB;
            OP_MOV:  exec_code = AC_MOV;
            default: exec_code = AC_ADD;
        endcase
    end

    // A wrapped add shows up as a sum smaller than the running accumulator.
    always_comb begin
        ovf_next = ovf | (au_t < acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= OP_ADD;
            cnt    <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flag   <= 1'b0;
            au_en  <= 1'b0;
            ac     <= '0;
            au_a   <= '0;
            au_b   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q <= op_in;
                        cnt  <= opb;
                        acc  <= '0;
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (op_in == OP_MUL) begin
                            if (opb == '0) begin
                                state  <= S_DONE;
                                result <= '0;
                                flag   <= 1'b0;
                                done   <= 1'b1;
                            end else begin
                                state <= S_ITER;
                                au_en <= 1'b1;
                                ac    <= AC_ADD;
                                au_a  <= opa;
                                au_b  <= '0;
                            end
                        end else begin
                            state <= S_EXEC;
                            au_en <= 1'b1;
                            ac    <= exec_code;
                            au_a  <= opa;
                            au_b  <= opb;
                        end
                    end
                end

                S_EXEC: begin
                    result <= au_t;
                    flag   <= (op_q == OP_SUB) ? au_gf : 1'b0;
                    au_en  <= 1'b0;
                    ac     <= '0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end

                S_ITER: begin
                    acc <= au_t;
                    cnt <= cnt - WIDTH'(1);
                    ovf <= ovf_next;
                    if (cnt == WIDTH'(1)) begin
                        result <= au_t;
                        flag   <= ovf_next;
                        au_en  <= 1'b0;
                        ac     <= '0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        // au_b tracks the accumulator so the next add uses the new sum.
                        au_b <= au_t;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    au_en <= 1'b0;
                    ac    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_au_seq.sv
// Scoreboard bench for au_seq: a behavioural AU closes the loop, stimulus queues
// expected completions and a monitor checks each done pulse against the queue.
module tb_au_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [7:0] opa = 8'h00;
    logic [7:0] opb = 8'h00;
    logic       busy, done, flag, au_en, au_gf;
    logic [7:0] result, au_a, au_b, au_t;
    logic [3:0] ac;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        string      name;
        logic [7:0] res;
        logic       flg;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t sb[$];

    au_seq #(.WIDTH(8), .AC_ADD(4'b1000), .AC_SUB(4'b1001), .AC_MOV(4'b0100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .flag(flag),
        .au_en(au_en), .ac(ac), .au_a(au_a), .au_b(au_b), .au_t(au_t), .au_gf(au_gf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural arithmetic unit
    always_comb begin
        au_t  = 8'h00;
        au_gf = 1'b0;
        if (au_en) begin
            case (ac)
                4'b1000: au_t = au_a + au_b;
                4'b1001: begin au_t = au_b - au_a; au_gf = (au_b >= au_a); end
                4'b0100: au_t = au_a;
                default: au_t = 8'h00;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_flag"}, flag, e.flg);
                chk({e.name, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 1, 0);
    endtask

    task automatic issue(input string nm, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ef,
                         input int lat);
        exp_t e;
        wait_idle();
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.name = nm; e.res = er; e.flg = ef; e.lat = lat; e.acc_cyc = cyc;
        sb.push_back(e);
        chk({nm, "_busy"}, busy, 1);
    endtask

    initial begin
        // Reset with start held high
        start = 1'b1; op = 2'b11; opa = 8'h03; opb = 8'h03;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flag", flag, 0);
        chk("rst_au_en", au_en, 0);
        chk("rst_ac", ac, 0);
        chk("rst_au_ab", {au_a, au_b}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        issue("add", 2'b00, 8'h25, 8'h13, 8'h38, 1'b0, 2);
        chk("add_ac", ac, 4'b1000);
        chk("add_au_en", au_en, 1);
        chk("add_operands", {au_a, au_b}, 16'h2513);
        issue("add_wrap", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b0, 2);
        issue("sub_ge", 2'b01, 8'h03, 8'h05, 8'h02, 1'b1, 2);
        chk("sub_ac", ac, 4'b1001);
        issue("sub_lt", 2'b01, 8'h05, 8'h03, 8'hFE, 1'b0, 2);
        issue("mul7x6", 2'b11, 8'h07, 8'h06, 8'h2A, 1'b0, 7);
        chk("mul_ac", ac, 4'b1000);
        issue("mul20x9", 2'b11, 8'h20, 8'h09, 8'h20, 1'b1, 10);
        issue("mul_zero", 2'b11, 8'h55, 8'h00, 8'h00, 1'b0, 1);
        chk("mul_zero_au_en", au_en, 0);
        issue("mov", 2'b10, 8'hA5, 8'h3C, 8'hA5, 1'b0, 2);
        chk("mov_ac", ac, 4'b0100);

        // start pulses during ITER and DONE are ignored
        issue("mul_ign", 2'b11, 8'h07, 8'h06, 8'h2A, 1'b0, 7);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        op = 2'b00; opa = 8'h01; opb = 8'h01; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_iter_busy", busy, 1);
        chk("ign_iter_ac", ac, 4'b1000);
        begin
            int n = 0;
            @(negedge clk);
            while (done !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (done !== 1'b1) chk("ign_done_timeout", 1, 0);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_done_idle", busy, 0);
        repeat (3) @(negedge clk);
        chk("ign_still_idle", busy, 0);
        chk("ign_queue_empty", sb.size(), 0);

        // Asynchronous reset during the 3rd ITER
        issue("mul_rst", 2'b11, 8'h07, 8'h06, 8'h2A, 1'b0, 7);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("pre_rst_result", result, 8'h2A);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("mid_rst_au_en", au_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("add_after_rst", 2'b00, 8'hF0, 8'h20, 8'h10, 1'b0, 2);

        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        end
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
